// File: rtl/dds_sweep_sequencer_if.sv
// Load handshake between the sweep sequencer and the AD9850 serial loader.
interface dds_sweep_sequencer_if #(
  parameter int unsigned TW_WIDTH = 32
);
  logic                load_valid;
  logic                load_ready;
  logic [TW_WIDTH-1:0] load_tw;
  logic [7:0]          load_ctrl;

  modport master (output load_valid, load_tw, load_ctrl, input load_ready);
  modport slave  (input load_valid, load_tw, load_ctrl, output load_ready);
endinterface

// File: rtl/dds_sweep_sequencer.sv
// AD9850 frequency-sweep sequencer: steps a tuning word with a per-word dwell,
// offers each word to the serial loader, and parks the DDS at 0 Hz on abort.
module dds_sweep_sequencer #(
  parameter int unsigned TW_WIDTH    = 32,
  parameter int unsigned STEP_WIDTH  = 16,
  parameter int unsigned DWELL_WIDTH = 24
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [TW_WIDTH-1:0]    cfg_start_tw,
  input  logic [TW_WIDTH-1:0]    cfg_step_tw,
  input  logic [STEP_WIDTH-1:0]  cfg_steps,
  input  logic [DWELL_WIDTH-1:0] cfg_dwell,
  input  logic                   cfg_repeat,
  dds_sweep_sequencer_if.master  load,
  output logic                   busy,
  output logic                   done,
  output logic                   aborted,
  output logic [STEP_WIDTH-1:0]  step_idx
);

  typedef enum logic [1:0] {IDLE, OFFER, DWELL, PARK} state_e;

  localparam logic [STEP_WIDTH-1:0]  STEP_ONE  = STEP_WIDTH'(1);
  localparam logic [DWELL_WIDTH-1:0] DWELL_ONE = DWELL_WIDTH'(1);

  state_e                 state_q, state_d;
  logic                   load_valid_q, load_valid_d;
  logic [TW_WIDTH-1:0]    load_tw_q, load_tw_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   aborted_q, aborted_d;
  logic [STEP_WIDTH-1:0]  step_idx_q, step_idx_d;
  logic [DWELL_WIDTH-1:0] dwell_cnt_q, dwell_cnt_d;
  logic                   abort_flag_q, abort_flag_d;
  logic [TW_WIDTH-1:0]    sh_start_tw_q, sh_start_tw_d;
  logic [TW_WIDTH-1:0]    sh_step_tw_q, sh_step_tw_d;
  logic [STEP_WIDTH-1:0]  sh_steps_q, sh_steps_d;
  logic [DWELL_WIDTH-1:0] sh_dwell_q, sh_dwell_d;
  logic                   sh_repeat_q, sh_repeat_d;
  logic                   xfer;

  assign xfer = load_valid_q && load.load_ready;

  always_comb begin
    state_d       = state_q;
    load_valid_d  = load_valid_q;
    load_tw_d     = load_tw_q;
    done_d        = 1'b0;
    aborted_d     = 1'b0;
    step_idx_d    = step_idx_q;
    dwell_cnt_d   = dwell_cnt_q;
    abort_flag_d  = abort_flag_q;
    sh_start_tw_d = sh_start_tw_q;
    sh_step_tw_d  = sh_step_tw_q;
    sh_steps_d    = sh_steps_q;
    sh_dwell_d    = sh_dwell_q;
    sh_repeat_d   = sh_repeat_q;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          sh_start_tw_d = cfg_start_tw;
          sh_step_tw_d  = cfg_step_tw;
          sh_steps_d    = cfg_steps;
          sh_dwell_d    = cfg_dwell;
          sh_repeat_d   = cfg_repeat;
          abort_flag_d  = 1'b0;
          step_idx_d    = '0;
          load_tw_d     = cfg_start_tw;
          load_valid_d  = 1'b1;
          state_d       = OFFER;
        end
      end
      OFFER: begin
        if (abort) abort_flag_d = 1'b1;
        if (xfer) begin
          if (abort_flag_q || abort) begin
            // load_valid stays high: the park word follows with no gap or dwell
            abort_flag_d = 1'b0;
            load_tw_d    = '0;
            state_d      = PARK;
          end else begin
            load_valid_d = 1'b0;
            dwell_cnt_d  = (sh_dwell_q == '0) ? DWELL_ONE : sh_dwell_q;
            state_d      = DWELL;
          end
        end
      end
      DWELL: begin
        // load_tw_q still holds the current word here and serves as the accumulator
        if (abort) begin
          load_valid_d = 1'b1;
          load_tw_d    = '0;
          state_d      = PARK;
        end else if (dwell_cnt_q <= DWELL_ONE) begin
          if (step_idx_q < sh_steps_q) begin
            load_tw_d    = load_tw_q + sh_step_tw_q;
            step_idx_d   = step_idx_q + STEP_ONE;
            load_valid_d = 1'b1;
            state_d      = OFFER;
          end else if (sh_repeat_q) begin
            load_tw_d    = sh_start_tw_q;
            step_idx_d   = '0;
            load_valid_d = 1'b1;
            state_d      = OFFER;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          dwell_cnt_d = dwell_cnt_q - DWELL_ONE;
        end
      end
      PARK: begin
        if (xfer) begin
          load_valid_d = 1'b0;
          aborted_d    = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      load_valid_q  <= 1'b0;
      load_tw_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
      step_idx_q    <= '0;
      dwell_cnt_q   <= '0;
      abort_flag_q  <= 1'b0;
      sh_start_tw_q <= '0;
      sh_step_tw_q  <= '0;
      sh_steps_q    <= '0;
      sh_dwell_q    <= '0;
      sh_repeat_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      load_valid_q  <= load_valid_d;
      load_tw_q     <= load_tw_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      aborted_q     <= aborted_d;
      step_idx_q    <= step_idx_d;
      dwell_cnt_q   <= dwell_cnt_d;
      abort_flag_q  <= abort_flag_d;
      sh_start_tw_q <= sh_start_tw_d;
      sh_step_tw_q  <= sh_step_tw_d;
      sh_steps_q    <= sh_steps_d;
      sh_dwell_q    <= sh_dwell_d;
      sh_repeat_q   <= sh_repeat_d;
    end
  end

  assign load.load_valid = load_valid_q;
  assign load.load_tw    = load_tw_q;
  assign load.load_ctrl  = '0;
  assign busy            = busy_q;
  assign done            = done_q;
  assign aborted         = aborted_q;
  assign step_idx        = step_idx_q;

endmodule
